// File: rtl/semaforo_pkg.sv
// Shared encodings for the traffic-light controller and the light block it drives.
package semaforo_pkg;

    // Lamp feedback codes, ordered {green, yellow, red}.
    localparam logic [2:0] LAMP_OFF    = 3'b000;
    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_ERROR  = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_ON,
        ST_HOLD_GREEN,
        ST_REQ_RED,
        ST_WAIT_RED,
        ST_HOLD_RED,
        ST_REQ_GREEN,
        ST_WAIT_GREEN,
        ST_FAULT
    } ctrl_state_e;

    typedef enum logic [2:0] {
        LS_OFF,
        LS_GREEN,
        LS_YELLOW_R,
        LS_RED,
        LS_YELLOW_G
    } light_state_e;

    function automatic logic [2:0] lamp_code(input light_state_e s);
        case (s)
            LS_GREEN:                 return LAMP_GREEN;
            LS_RED:                   return LAMP_RED;
            LS_YELLOW_R, LS_YELLOW_G: return LAMP_YELLOW;
            default:                  return LAMP_OFF;
        endcase
    endfunction

    // True for any pattern with more than one lamp lit (includes LAMP_ERROR).
    function automatic logic lamp_multi(input logic [2:0] fb);
        return !(fb inside {LAMP_OFF, LAMP_RED, LAMP_YELLOW, LAMP_GREEN});
    endfunction

endpackage

// File: rtl/semaforo_ped_sync.sv
// Pedestrian button: 2-flop synchronizer followed by a rising-edge detector.
module semaforo_ped_sync (
    input  logic clklf,
    input  logic reset,
    input  logic ped_req,
    output logic ped_pulse
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], ped_req};
    end

    always_ff @(posedge clklf) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the synchronized level; sync_q[2] is its previous value.
    assign ped_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light sequencer: commands the light block and checks every transition
// against lamp feedback, dropping into a sticky FAULT on anything unexpected.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int T_GREEN     = 40000,
    parameter int T_GREEN_MIN = 10000,
    parameter int T_RED       = 20000,
    parameter int T_ACK       = 32768
) (
    input  logic        clklf,
    input  logic        reset,
    input  logic        enable,
    input  logic        start_red,
    input  logic        ped_req,
    input  logic        green_i,
    input  logic        yellow_i,
    input  logic        red_i,
    output logic        en,
    output logic        set,
    output logic        change,
    output logic        ped_walk,
    output logic        fault,
    output ctrl_state_e state_dbg,
    output logic        ped_pend_dbg
);

    if (T_GREEN_MIN < 1 || T_GREEN_MIN > T_GREEN || T_RED < 1 || T_ACK < 1 ||
        longint'(T_GREEN) >= (longint'(1) << CNT_W) ||
        longint'(T_RED)   >= (longint'(1) << CNT_W) ||
        longint'(T_ACK)   >= (longint'(1) << CNT_W)) begin : g_bad_params
        $error("semaforo_ctrl: timing parameters out of range");
    end

    localparam logic [CNT_W-1:0] G_LAST    = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] R_LAST    = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(T_ACK - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] ack_q, ack_d;
    logic             en_q, en_d, set_q, set_d, change_q, change_d;
    logic             walk_q, walk_d, fault_q, fault_d, ped_pend_q, ped_pend_d;
    logic             ped_pulse, fault_cond, ack_out;
    logic [2:0]       fb;

    semaforo_ped_sync u_ped_sync (
        .clklf     (clklf),
        .reset     (reset),
        .ped_req   (ped_req),
        .ped_pulse (ped_pulse)
    );

    assign fb      = {green_i, yellow_i, red_i};
    assign ack_out = (ack_q >= ACK_LAST);

    // Command handshake: change is a request held high until the lamps answer
    // with YELLOW, then dropped on the next cycle so it is already low by the
    // time the target colour shows; the light treats change as a toggle.
    always_comb begin
        case (state_q)
            ST_WAIT_ON, ST_REQ_RED, ST_REQ_GREEN:
                fault_cond = lamp_multi(fb) || ack_out;
            ST_WAIT_RED:
                fault_cond = ack_out || !(fb == LAMP_YELLOW || fb == LAMP_RED);
            ST_WAIT_GREEN:
                fault_cond = ack_out || !(fb == LAMP_YELLOW || fb == LAMP_GREEN);
            ST_HOLD_GREEN: fault_cond = (fb != LAMP_GREEN);
            ST_HOLD_RED:   fault_cond = (fb != LAMP_RED);
            default:       fault_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        set_d    = set_q;
        change_d = change_q;
        walk_d   = walk_q;
        fault_d  = fault_q;

        if (state_q == ST_FAULT) begin
            state_d = ST_FAULT;
        end else if (fault_cond) begin
            state_d  = ST_FAULT;
            en_d     = 1'b0;
            change_d = 1'b0;
            walk_d   = 1'b0;
            fault_d  = 1'b1;
        end else if (!enable && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            en_d     = 1'b0;
            change_d = 1'b0;
            walk_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (enable) begin
                    state_d = ST_WAIT_ON;
                    en_d    = 1'b1;
                    set_d   = start_red;
                end
                ST_WAIT_ON: if (fb == (set_q ? LAMP_RED : LAMP_GREEN)) begin
                    state_d = set_q ? ST_HOLD_RED : ST_HOLD_GREEN;
                    walk_d  = set_q;
                end
                ST_HOLD_GREEN: if (dwell_q == G_LAST || (ped_pend_q && dwell_q >= GMIN_LAST)) begin
                    state_d  = ST_REQ_RED;
                    change_d = 1'b1;
                end
                ST_REQ_RED: if (fb == LAMP_YELLOW) begin
                    state_d  = ST_WAIT_RED;
                    change_d = 1'b0;
                end
                ST_WAIT_RED: if (fb == LAMP_RED) begin
                    state_d = ST_HOLD_RED;
                    walk_d  = 1'b1;
                end
                ST_HOLD_RED: if (dwell_q == R_LAST) begin
                    state_d  = ST_REQ_GREEN;
                    change_d = 1'b1;
                    walk_d   = 1'b0;
                end
                ST_REQ_GREEN: if (fb == LAMP_YELLOW) begin
                    state_d  = ST_WAIT_GREEN;
                    change_d = 1'b0;
                end
                ST_WAIT_GREEN: if (fb == LAMP_GREEN) begin
                    state_d = ST_HOLD_GREEN;
                end
                default: state_d = state_q;
            endcase
        end

        // Both counters restart on every state entry and only run where they matter.
        dwell_d = '0;
        ack_d   = '0;
        if (state_d == state_q) begin
            if (state_q inside {ST_HOLD_GREEN, ST_HOLD_RED}) begin
                dwell_d = sat_inc(dwell_q);
            end
            if (state_q inside {ST_WAIT_ON, ST_REQ_RED, ST_REQ_GREEN, ST_WAIT_RED, ST_WAIT_GREEN}) begin
                ack_d = sat_inc(ack_q);
            end
        end

        if (state_d == ST_HOLD_RED || state_q == ST_HOLD_RED) begin
            ped_pend_d = 1'b0;
        end else if (ped_pulse) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end

    always_ff @(posedge clklf) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            ack_q      <= '0;
            en_q       <= 1'b0;
            set_q      <= 1'b0;
            change_q   <= 1'b0;
            walk_q     <= 1'b0;
            fault_q    <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            ack_q      <= ack_d;
            en_q       <= en_d;
            set_q      <= set_d;
            change_q   <= change_d;
            walk_q     <= walk_d;
            fault_q    <= fault_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    assign en           = en_q;
    assign set          = set_q;
    assign change       = change_q;
    assign ped_walk     = walk_q;
    assign fault        = fault_q;
    assign state_dbg    = state_q;
    assign ped_pend_dbg = ped_pend_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: a 2-cycle-lag light model with 5-cycle yellow closes the loop.
module tb_semaforo_ctrl;
    import semaforo_pkg::*;

    localparam int T_GREEN     = 50;
    localparam int T_GREEN_MIN = 10;
    localparam int T_RED       = 40;
    localparam int T_ACK       = 20;

    logic        clklf = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        start_red = 1'b0;
    logic        ped_req = 1'b0;
    logic        green_i, yellow_i, red_i;
    logic        en, set, change, ped_walk, fault;
    ctrl_state_e state_dbg;
    logic        ped_pend_dbg;

    // light model controls
    light_state_e ls;
    logic [2:0]   ycnt;
    logic [2:0]   lamp_q;
    logic         no_yellow = 1'b0;
    logic         inj_en = 1'b0;
    logic [2:0]   inj_val = 3'b000;
    logic [2:0]   fb;
    logic [2:0]   prev_fb = 3'b000;

    int n_checks = 0;
    int n_fail   = 0;

    semaforo_ctrl #(
        .CNT_W(16), .T_GREEN(T_GREEN), .T_GREEN_MIN(T_GREEN_MIN), .T_RED(T_RED), .T_ACK(T_ACK)
    ) dut (
        .clklf(clklf), .reset(reset), .enable(enable), .start_red(start_red), .ped_req(ped_req),
        .green_i(green_i), .yellow_i(yellow_i), .red_i(red_i),
        .en(en), .set(set), .change(change), .ped_walk(ped_walk), .fault(fault),
        .state_dbg(state_dbg), .ped_pend_dbg(ped_pend_dbg)
    );

    always #5 clklf = ~clklf;

    assign fb = inj_en ? inj_val : lamp_q;
    assign {green_i, yellow_i, red_i} = fb;

    always @(posedge clklf) begin
        if (reset) begin
            ls     <= LS_OFF;
            ycnt   <= 3'd0;
            lamp_q <= LAMP_OFF;
        end else begin
            lamp_q <= lamp_code(ls);
            if (!en) begin
                ls <= LS_OFF;
            end else begin
                case (ls)
                    LS_OFF:   ls <= set ? LS_RED : LS_GREEN;
                    LS_GREEN: if (change && !no_yellow) begin ls <= LS_YELLOW_R; ycnt <= 3'd0; end
                    LS_RED:   if (change) begin ls <= LS_YELLOW_G; ycnt <= 3'd0; end
                    LS_YELLOW_R: if (ycnt == 3'd4) ls <= LS_RED;   else ycnt <= ycnt + 3'd1;
                    LS_YELLOW_G: if (ycnt == 3'd4) ls <= LS_GREEN; else ycnt <= ycnt + 3'd1;
                    default:  ls <= LS_OFF;
                endcase
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_st(input string name, input ctrl_state_e act, input ctrl_state_e exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s", name, act.name(), exp.name());
        end
    endtask

    task automatic check_outs(input string name, input logic e_en, input logic e_set,
                              input logic e_ch, input logic e_walk, input logic e_fault,
                              input ctrl_state_e e_st);
        check_bit({name, ".en"}, en, e_en);
        check_bit({name, ".set"}, set, e_set);
        check_bit({name, ".change"}, change, e_ch);
        check_bit({name, ".ped_walk"}, ped_walk, e_walk);
        check_bit({name, ".fault"}, fault, e_fault);
        check_st({name, ".state"}, state_dbg, e_st);
    endtask

    // Once the lamps leave YELLOW for a colour, change must already be low.
    always @(negedge clklf) begin
        if (!reset && prev_fb == LAMP_YELLOW && fb != LAMP_YELLOW && fb != LAMP_OFF)
            check_bit("change_low_after_yellow", change, 1'b0);
        prev_fb <= fb;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clklf);
        #1;
    endtask

    // Leaves the bench one edge before the controller first sees enable=1 ("edge 0").
    task automatic restart(input logic sr);
        reset = 1'b1; enable = 1'b0; ped_req = 1'b0;
        inj_en = 1'b0; no_yellow = 1'b0;
        tick(3);
        reset = 1'b0; enable = 1'b1; start_red = sr;
    endtask

    typedef struct {
        int          adv;
        logic        e_en, e_set, e_ch, e_walk, e_fault;
        ctrl_state_e e_st;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // edge numbers are counted from reset release
        vecs[0]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_WAIT_ON};    // edge 1
        vecs[1]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_HOLD_GREEN}; // edge 4
        vecs[2]  = '{49, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_HOLD_GREEN}; // edge 53
        vecs[3]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_RED};    // edge 54
        vecs[4]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_RED};    // edge 56
        vecs[5]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_WAIT_RED};   // edge 57
        vecs[6]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_WAIT_RED};   // edge 61
        vecs[7]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_HOLD_RED};   // edge 62
        vecs[8]  = '{39, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_HOLD_RED};   // edge 101
        vecs[9]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_GREEN};  // edge 102
        vecs[10] = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_WAIT_GREEN}; // edge 105
        vecs[11] = '{5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_HOLD_GREEN}; // edge 110
        vecs[12] = '{49, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_HOLD_GREEN}; // edge 159
        vecs[13] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_RED};    // edge 160

        // reset state
        reset = 1'b1;
        tick(3);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        check_bit("reset.ped_pend", ped_pend_dbg, 1'b0);

        // normal cycle, table-driven
        restart(1'b0);
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].adv);
            check_outs($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_set, vecs[i].e_ch,
                       vecs[i].e_walk, vecs[i].e_fault, vecs[i].e_st);
        end

        // pedestrian request at green dwell 3 shortens green to 10 cycles
        restart(1'b0);
        tick(7);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        tick(5);                                                   // edge 13
        check_outs("ped.e13", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_HOLD_GREEN);
        check_bit("ped.e13.pend", ped_pend_dbg, 1'b1);
        tick(1);                                                   // edge 14
        check_outs("ped.e14", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_RED);
        tick(7);                                                   // edge 21
        check_st("ped.e21.state", state_dbg, ST_WAIT_RED);
        check_bit("ped.e21.pend", ped_pend_dbg, 1'b1);
        tick(1);                                                   // edge 22
        check_outs("ped.e22", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_HOLD_RED);
        check_bit("ped.e22.pend", ped_pend_dbg, 1'b0);
        tick(2);
        ped_req = 1'b1;                                            // press inside HOLD_RED
        tick(1);
        ped_req = 1'b0;
        tick(5);                                                   // edge 30
        check_bit("ped.ignored.pend", ped_pend_dbg, 1'b0);
        // reset at HOLD_RED dwell 17
        tick(9);                                                   // edge 39
        check_outs("rst.e39", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_HOLD_RED);
        reset = 1'b1;
        tick(1);
        check_outs("rst.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        check_bit("rst.after.pend", ped_pend_dbg, 1'b0);

        // light never answers with YELLOW: ack timeout 20 cycles after REQ_RED entry
        restart(1'b0);
        no_yellow = 1'b1;
        tick(73);
        check_outs("ack.e73", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_RED);
        tick(1);
        check_outs("ack.e74", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_FAULT);
        enable = 1'b0;
        tick(3);
        enable = 1'b1; start_red = 1'b1;
        tick(3);
        check_outs("ack.sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_FAULT);
        reset = 1'b1;
        tick(1);
        check_outs("ack.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);

        // ERROR pattern during HOLD_GREEN
        restart(1'b0);
        tick(20);
        check_outs("err.e20", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_HOLD_GREEN);
        inj_en = 1'b1; inj_val = LAMP_ERROR;
        tick(1);
        check_outs("err.e21", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_FAULT);
        inj_en = 1'b0;

        // two-lamp pattern during WAIT_RED
        restart(1'b0);
        tick(58);
        check_outs("multi.e58", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_WAIT_RED);
        inj_en = 1'b1; inj_val = 3'b110;
        tick(1);
        check_outs("multi.e59", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_FAULT);
        inj_en = 1'b0;

        // enable drop mid-REQ_RED, then restart into red
        restart(1'b0);
        tick(55);
        check_outs("dis.e55", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ_RED);
        enable = 1'b0;
        tick(1);
        check_outs("dis.e56", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        enable = 1'b1; start_red = 1'b1;
        tick(1);
        check_outs("dis.e57", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST_WAIT_ON);
        tick(3);
        check_outs("dis.e60", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ST_HOLD_RED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
